// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one instruction-memory read in flight and
// buffers returned words in a small prefetch FIFO feeding decode over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_pop, count_nxt;
  logic [ENT_W-1:0]  head_nxt;

  logic              push, pop;
  logic [ADDR_W-1:0] target;

  // Redirect wins over everything: wrong-path pushes and pops are suppressed.
  assign target    = branch_target & ~ADDR_W'(3);
  assign pop       = dec_valid & dec_ready & ~branch_taken;
  assign push      = (state == S_REQ) & imem_ack & ~branch_taken;
  assign count_pop = count - CNT_W'(pop);

  // FIFO bookkeeping and next head word (bypass when the pushed word becomes head).
  always_comb begin
    count_nxt  = count_pop + CNT_W'(push);
    wr_ptr_nxt = wr_ptr + PTR_W'(push);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    head_nxt   = '0;
    if (branch_taken) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else if (count_nxt != '0) begin
      if (count_pop == '0) head_nxt = {imem_addr, imem_rdata};
      else                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Request FSM: next state, next request and fetch PC.
  always_comb begin
    state_nxt    = state;
    req_nxt      = imem_req;
    addr_nxt     = imem_addr;
    fetch_pc_nxt = fetch_pc;
    case (state)
      S_IDLE: begin
        if (branch_taken) begin
          fetch_pc_nxt = target;
          req_nxt      = 1'b1;
          addr_nxt     = target;
          state_nxt    = S_REQ;
        end else if (count_pop < DEPTH_C) begin
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (branch_taken) begin
          fetch_pc_nxt = target;
          if (imem_ack) begin
            addr_nxt = target;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else if (imem_ack) begin
          fetch_pc_nxt = fetch_pc + ADDR_W'(4);
          if (count_nxt < DEPTH_C) begin
            addr_nxt = fetch_pc + ADDR_W'(4);
          end else begin
            req_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (branch_taken) fetch_pc_nxt = target;
        if (imem_ack) begin
          req_nxt   = 1'b1;
          addr_nxt  = branch_taken ? target : fetch_pc;
          state_nxt = S_REQ;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      dec_instr <= '0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
      count     <= count_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      dec_valid <= (count_nxt != '0);
      {dec_pc, dec_instr} <= head_nxt;
    end
  end

  // Prefetch storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {imem_addr, imem_rdata};
  end

endmodule
